// File: rtl/w25q_pkg.sv
// Shared opcodes, status-bit position and sequencer state type for the W25Q page-program controller.
package w25q_pkg;

  localparam logic [7:0] CMD_WREN   = 8'h06;
  localparam logic [7:0] CMD_PP     = 8'h02;
  localparam logic [7:0] CMD_RDSR1  = 8'h05;
  localparam logic [7:0] DUMMY_BYTE = 8'hFF;

  localparam int unsigned SR_WIP_BIT = 0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WREN,
    ST_GAP1,
    ST_PP_CMD,
    ST_PP_ADDR,
    ST_PP_DATA,
    ST_GAP2,
    ST_RDSR_CMD,
    ST_RDSR_POLL,
    ST_FIN,
    ST_ERR
  } state_t;

endpackage

// File: rtl/spi_cs_gap_timer.sv
// Chip-select gap timer: load to CS_GAP, count down to zero, report expiry.
module spi_cs_gap_timer #(
  parameter int unsigned CS_GAP = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expired_c
);

  localparam int unsigned CW = (CS_GAP > 0) ? $clog2(CS_GAP + 1) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(CS_GAP);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expired_c = (cnt == '0);

endmodule

// File: rtl/w25q_page_prog_ctrl.sv
// W25Q page-program sequencer: WREN, PP + address + payload, then RDSR1 polling until WIP clears.
// Optional build macro ADDR_ALIGN_CHECK_EN rejects starts whose payload would cross a page boundary.
module w25q_page_prog_ctrl
  import w25q_pkg::*;
#(
  parameter int unsigned PAGE_BYTES = 256,
  parameter int unsigned POLL_MAX   = 50000,
  parameter int unsigned CS_GAP     = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic [23:0] addr,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [9:0]  byte_idx,
  input  logic [7:0]  tbl_data,
  output logic        cs_req,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data
);

  localparam int unsigned LAST_BYTE = PAGE_BYTES - 1;

  state_t      state, state_d;
  logic        busy_d, done_d, error_d, cs_req_d, tx_valid_d;
  logic [7:0]  tx_data_d;
  logic [7:0]  idx_q, idx_d;
  logic [8:0]  data_cnt_q, data_cnt_d;
  logic [1:0]  addr_cnt_q, addr_cnt_d;
  logic [15:0] poll_cnt_q, poll_cnt_d;
  logic [23:0] addr_q, addr_d;
  logic        pend_q, pend_d;

  logic        accept_c, rx_done_c, issue_c, gap_load_c, gap_expired_c;
  logic        align_fault_c;
  logic [15:0] poll_inc_c;
  logic        status_unused;

`ifdef ADDR_ALIGN_CHECK_EN
  assign align_fault_c = (10'(addr[7:0]) + 10'(PAGE_BYTES)) > 10'd256;
`else
  assign align_fault_c = 1'b0;
`endif

  // Only bit SR_WIP_BIT of the status byte matters here.
  assign status_unused = ^rx_data;

  assign byte_idx = {2'b00, idx_q};

  spi_cs_gap_timer #(
    .CS_GAP(CS_GAP)
  ) u_gap_timer (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .load     (gap_load_c),
    .expired_c(gap_expired_c)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      cs_req     <= 1'b0;
      tx_valid   <= 1'b0;
      tx_data    <= 8'h00;
      idx_q      <= 8'h00;
      data_cnt_q <= 9'd0;
      addr_cnt_q <= 2'd0;
      poll_cnt_q <= 16'd0;
      addr_q     <= 24'h0;
      pend_q     <= 1'b0;
    end else begin
      state      <= state_d;
      busy       <= busy_d;
      done       <= done_d;
      error      <= error_d;
      cs_req     <= cs_req_d;
      tx_valid   <= tx_valid_d;
      tx_data    <= tx_data_d;
      idx_q      <= idx_d;
      data_cnt_q <= data_cnt_d;
      addr_cnt_q <= addr_cnt_d;
      poll_cnt_q <= poll_cnt_d;
      addr_q     <= addr_d;
      pend_q     <= pend_d;
    end
  end

  always_comb begin
    state_d    = state;
    busy_d     = busy;
    done_d     = 1'b0;
    error_d    = 1'b0;
    cs_req_d   = cs_req;
    tx_valid_d = tx_valid;
    tx_data_d  = tx_data;
    idx_d      = idx_q;
    data_cnt_d = data_cnt_q;
    addr_cnt_d = addr_cnt_q;
    poll_cnt_d = poll_cnt_q;
    addr_d     = addr_q;
    pend_d     = pend_q;
    gap_load_c = 1'b0;
    poll_inc_c = (poll_cnt_q == 16'hFFFF) ? poll_cnt_q : poll_cnt_q + 16'd1;

    // A byte is outstanding from acceptance until its rx_valid; stray rx_valid is ignored.
    accept_c  = tx_valid && tx_ready;
    rx_done_c = pend_q && rx_valid;
    issue_c   = !tx_valid && !pend_q;
    if (accept_c) begin
      tx_valid_d = 1'b0;
      pend_d     = 1'b1;
    end
    if (rx_done_c) begin
      pend_d = 1'b0;
    end

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          addr_d     = addr;
          busy_d     = 1'b1;
          idx_d      = 8'h00;
          data_cnt_d = 9'd0;
          addr_cnt_d = 2'd0;
          poll_cnt_d = 16'd0;
          state_d    = align_fault_c ? ST_ERR : ST_WREN;
        end
      end

      ST_WREN: begin
        cs_req_d = 1'b1;
        if (issue_c) begin
          tx_valid_d = 1'b1;
          tx_data_d  = CMD_WREN;
        end
        if (rx_done_c) begin
          cs_req_d   = 1'b0;
          gap_load_c = 1'b1;
          state_d    = ST_GAP1;
        end
      end

      ST_GAP1: begin
        if (gap_expired_c) state_d = ST_PP_CMD;
      end

      ST_PP_CMD: begin
        cs_req_d = 1'b1;
        if (issue_c) begin
          tx_valid_d = 1'b1;
          tx_data_d  = CMD_PP;
        end
        if (rx_done_c) begin
          addr_cnt_d = 2'd0;
          state_d    = ST_PP_ADDR;
        end
      end

      ST_PP_ADDR: begin
        if (issue_c) begin
          tx_valid_d = 1'b1;
          unique case (addr_cnt_q)
            2'd0:    tx_data_d = addr_q[23:16];
            2'd1:    tx_data_d = addr_q[15:8];
            default: tx_data_d = addr_q[7:0];
          endcase
        end
        if (rx_done_c) begin
          if (addr_cnt_q == 2'd2) state_d = ST_PP_DATA;
          else                    addr_cnt_d = addr_cnt_q + 2'd1;
        end
      end

      ST_PP_DATA: begin
        if (issue_c) begin
          tx_valid_d = 1'b1;
          tx_data_d  = tbl_data;
        end
        // Index holds on the final byte so its upper bits never leave zero.
        if (accept_c && (data_cnt_q != 9'(LAST_BYTE))) begin
          idx_d = idx_q + 8'd1;
        end
        if (rx_done_c) begin
          if (data_cnt_q == 9'(LAST_BYTE)) begin
            idx_d      = 8'h00;
            data_cnt_d = 9'd0;
            cs_req_d   = 1'b0;
            gap_load_c = 1'b1;
            state_d    = ST_GAP2;
          end else begin
            data_cnt_d = data_cnt_q + 9'd1;
          end
        end
      end

      ST_GAP2: begin
        if (gap_expired_c) state_d = ST_RDSR_CMD;
      end

      ST_RDSR_CMD: begin
        cs_req_d = 1'b1;
        if (issue_c) begin
          tx_valid_d = 1'b1;
          tx_data_d  = CMD_RDSR1;
        end
        if (rx_done_c) state_d = ST_RDSR_POLL;
      end

      ST_RDSR_POLL: begin
        if (issue_c) begin
          tx_valid_d = 1'b1;
          tx_data_d  = DUMMY_BYTE;
        end
        if (rx_done_c) begin
          poll_cnt_d = poll_inc_c;
          if (!rx_data[SR_WIP_BIT]) begin
            cs_req_d = 1'b0;
            state_d  = ST_FIN;
          end else if (poll_inc_c >= 16'(POLL_MAX)) begin
            cs_req_d = 1'b0;
            state_d  = ST_ERR;
          end
        end
      end

      ST_FIN: begin
        cs_req_d = 1'b0;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end

      ST_ERR: begin
        cs_req_d = 1'b0;
        error_d  = 1'b1;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_w25q_page_prog_ctrl.sv
// Directed bench for w25q_page_prog_ctrl with a byte-level SPI shifter model and a page table.
module tb_w25q_page_prog_ctrl;
  import w25q_pkg::*;

  localparam int unsigned PAGE = 256;
  localparam int unsigned PMAX = 8;
  localparam int unsigned GAP  = 4;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        start   = 1'b0;
  logic [23:0] addr    = 24'h0;
  logic        busy, done, error, cs_req, tx_valid;
  logic [9:0]  byte_idx;
  logic [7:0]  tbl_data, tx_data;
  logic        tx_ready = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data  = 8'h00;

  int n_tests = 0;
  int n_fail  = 0;

  // Monitor / shifter-model state
  logic [7:0] byte_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] status_q[$];
  logic [7:0] sticky = 8'h00;
  logic [7:0] resp = 8'h00;
  logic [7:0] frame_first = 8'h00;
  logic [7:0] hold_data = 8'h00;
  logic       acc_pend = 1'b0, hold = 1'b0, cs_prev = 1'b0, rand_mode = 1'b0;
  int frames, frame_len, min_gap, low_run, done_cnt, err_cnt, dummy_cnt;
  int idx_err, stab_err, hi_err, cs_err, exp_idx;

  always #5 sys_clk = ~sys_clk;

  function automatic logic [7:0] tbl_fn(input logic [7:0] i);
    return (i * 8'd7) ^ 8'h5A;
  endfunction

  assign tbl_data = tbl_fn(byte_idx[7:0]);

  w25q_page_prog_ctrl #(
    .PAGE_BYTES(PAGE),
    .POLL_MAX  (PMAX),
    .CS_GAP    (GAP)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .start   (start),
    .addr    (addr),
    .busy    (busy),
    .done    (done),
    .error   (error),
    .byte_idx(byte_idx),
    .tbl_data(tbl_data),
    .cs_req  (cs_req),
    .tx_valid(tx_valid),
    .tx_data (tx_data),
    .tx_ready(tx_ready),
    .rx_valid(rx_valid),
    .rx_data (rx_data)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Shifter model: decides tx_ready and returns rx one cycle after each accepted byte.
  initial begin
    frames = 0; frame_len = 0; min_gap = 999; low_run = 0; done_cnt = 0; err_cnt = 0;
    dummy_cnt = 0; idx_err = 0; stab_err = 0; hi_err = 0; cs_err = 0; exp_idx = 0;
    forever begin
      @(negedge sys_clk);
      if (sys_rst) begin
        rx_valid = 1'b0; acc_pend = 1'b0; tx_ready = 1'b0; hold = 1'b0; cs_prev = 1'b0;
      end else begin
        rx_valid = 1'b0;
        if (acc_pend) begin
          rx_valid = 1'b1; rx_data = resp; acc_pend = 1'b0;
        end
        if (done) done_cnt++;
        if (error) err_cnt++;
        if (byte_idx[9:8] != 2'b00) hi_err++;
        if (tx_valid && !cs_req) cs_err++;
        if (cs_req && !cs_prev) begin
          if (frames > 0 && low_run < min_gap) min_gap = low_run;
          frames++; frame_len = 0; low_run = 0;
        end
        if (!cs_req && busy) low_run++;
        if (hold && (!tx_valid || tx_data != hold_data)) stab_err++;
        tx_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        if (tx_valid && tx_ready) begin
          byte_q.push_back(tx_data);
          if (frame_len == 0) frame_first = tx_data;
          if (frame_first == CMD_PP && frame_len >= 4) begin
            if (byte_idx[7:0] != 8'(exp_idx)) idx_err++;
            if (tx_data != tbl_fn(8'(exp_idx))) idx_err++;
            exp_idx++;
          end
          if (frame_first == CMD_RDSR1 && frame_len >= 1) begin
            dummy_cnt++;
            resp = (status_q.size() > 0) ? status_q.pop_front() : sticky;
          end else begin
            resp = 8'h00;
          end
          frame_len++; acc_pend = 1'b1; hold = 1'b0;
        end else begin
          hold = tx_valid; hold_data = tx_data;
        end
        cs_prev = cs_req;
      end
    end
  end

  task automatic clear_stats();
    byte_q.delete(); status_q.delete();
    frames = 0; min_gap = 999; low_run = 0; done_cnt = 0; err_cnt = 0; dummy_cnt = 0;
    idx_err = 0; stab_err = 0; hi_err = 0; cs_err = 0; exp_idx = 0;
  endtask

  task automatic pulse_start(input logic [23:0] a);
    @(negedge sys_clk);
    addr = a; start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int cyc = 0;
    while (busy && cyc < 20000) begin
      @(negedge sys_clk);
      cyc++;
    end
    repeat (3) @(negedge sys_clk);
    check_eq({tag, "_timeout"}, 32'(cyc >= 20000), 32'd0);
  endtask

  task automatic build_exp(input logic [23:0] a, input int n_dummy);
    exp_q.delete();
    exp_q.push_back(CMD_WREN); exp_q.push_back(CMD_PP);
    exp_q.push_back(a[23:16]); exp_q.push_back(a[15:8]); exp_q.push_back(a[7:0]);
    for (int i = 0; i < int'(PAGE); i++) exp_q.push_back(tbl_fn(8'(i)));
    exp_q.push_back(CMD_RDSR1);
    for (int i = 0; i < n_dummy; i++) exp_q.push_back(DUMMY_BYTE);
  endtask

  task automatic check_stream(input string tag);
    int mism = 0;
    check_eq({tag, "_len"}, 32'(byte_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < byte_q.size(); i++)
      if (byte_q[i] !== exp_q[i]) mism++;
    check_eq({tag, "_bytes"}, 32'(mism), 32'd0);
  endtask

  task automatic check_clean_run(input string tag, input logic [23:0] a, input int n_dummy);
    build_exp(a, n_dummy);
    check_stream(tag);
    check_eq({tag, "_frames"}, 32'(frames), 32'd3);
    check_eq({tag, "_gap_ge4"}, 32'(min_gap >= 4), 32'd1);
    check_eq({tag, "_done"}, 32'(done_cnt), 32'd1);
    check_eq({tag, "_err"}, 32'(err_cnt), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_cs"}, 32'(cs_req), 32'd0);
    check_eq({tag, "_idx"}, 32'(idx_err), 32'd0);
    check_eq({tag, "_hold"}, 32'(stab_err), 32'd0);
    check_eq({tag, "_hibits"}, 32'(hi_err), 32'd0);
    check_eq({tag, "_cs_valid"}, 32'(cs_err), 32'd0);
  endtask

  initial begin
    int cyc;
    int d0, e0;
    repeat (3) @(negedge sys_clk);
    check_eq("rst_outputs", 32'({busy, done, error, cs_req, tx_valid, tx_data, byte_idx}), 32'd0);
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    // Nominal: status 03, 03, 00
    clear_stats();
    rand_mode = 1'b0;
    status_q.push_back(8'h03); status_q.push_back(8'h03); status_q.push_back(8'h00);
    sticky = 8'h00;
    pulse_start(24'h001000);
    check_eq("nom_busy", 32'(busy), 32'd1);
    wait_idle("nom");
    check_clean_run("nom", 24'h001000, 3);

    // Backpressure plus a second start while busy
    clear_stats();
    rand_mode = 1'b1;
    status_q.push_back(8'h00);
    pulse_start(24'h123400);
    repeat (30) @(negedge sys_clk);
    pulse_start(24'hFFFF00);
    wait_idle("bp");
    check_clean_run("bp", 24'h123400, 1);
    rand_mode = 1'b0;
    repeat (5) @(negedge sys_clk);
    check_eq("ign_start_busy", 32'(busy), 32'd0);
    check_eq("ign_start_done", 32'(done_cnt), 32'd1);

    // Timeout: WIP never clears
    clear_stats();
    sticky = 8'h01;
    pulse_start(24'h002000);
    wait_idle("to");
    build_exp(24'h002000, int'(PMAX));
    check_stream("to");
    check_eq("to_dummies", 32'(dummy_cnt), 32'(PMAX));
    check_eq("to_err", 32'(err_cnt), 32'd1);
    check_eq("to_done", 32'(done_cnt), 32'd0);
    check_eq("to_cs", 32'(cs_req), 32'd0);
    sticky = 8'h00;

    // Reset in the middle of the payload
    clear_stats();
    pulse_start(24'h000200);
    cyc = 0;
    while (byte_idx != 10'd100 && cyc < 5000) begin
      @(negedge sys_clk);
      cyc++;
    end
    check_eq("rst_mid_reach100", 32'(cyc >= 5000), 32'd0);
    d0 = done_cnt; e0 = err_cnt;
    #2 sys_rst = 1'b1;
    #1 check_eq("rst_mid_outputs", 32'({busy, done, error, cs_req, tx_valid, tx_data, byte_idx}), 32'd0);
    repeat (3) @(negedge sys_clk);
    check_eq("rst_mid_no_pulse", 32'(done_cnt - d0 + err_cnt - e0), 32'd0);
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);
    clear_stats();
    status_q.push_back(8'h00);
    pulse_start(24'h000300);
    wait_idle("after_rst");
    check_clean_run("after_rst", 24'h000300, 1);

    // Misaligned start address
    clear_stats();
    status_q.push_back(8'h00);
`ifdef ADDR_ALIGN_CHECK_EN
    @(negedge sys_clk);
    addr = 24'h000010; start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    @(negedge sys_clk);
    check_eq("align_err_t2", 32'(error), 32'd1);
    repeat (5) @(negedge sys_clk);
    check_eq("align_err_cnt", 32'(err_cnt), 32'd1);
    check_eq("align_frames", 32'(frames), 32'd0);
    check_eq("align_done", 32'(done_cnt), 32'd0);
    check_eq("align_busy", 32'(busy), 32'd0);
`else
    pulse_start(24'h000010);
    wait_idle("unalign");
    check_clean_run("unalign", 24'h000010, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
